// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer: steps NS/EW green-yellow phases off the shared
// seconds countdown, with night flashing-yellow mode and run/pause hold.
module traffic_phase_ctrl #(
  parameter int unsigned pRed_Count_Sec    = 18,
  parameter int unsigned pYellow_Count_Sec = 3,
  parameter int unsigned pGreen_Count_Sec  = 15,
  parameter int unsigned pCount_width      = $clog2(pRed_Count_Sec)
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    sec_tick,
  input  logic                    light_tick,
  input  logic                    run,
  input  logic                    night_mode,
  output logic                    cnt_en,
  output logic                    ctr_load,
  output logic [pCount_width-1:0] load_count,
  output logic [2:0]              ns_light,
  output logic [2:0]              ew_light,
  output logic [2:0]              phase
);

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    EW_GRN = 3'd2,
    EW_YEL = 3'd3,
    FLASH  = 3'd4
  } state_e;

  localparam logic [pCount_width-1:0] LD_GRN = pCount_width'(pGreen_Count_Sec - 1);
  localparam logic [pCount_width-1:0] LD_YEL = pCount_width'(pYellow_Count_Sec - 1);

  state_e state_q, state_d;
  logic   blink_q, blink_d;
  logic   adv;

  function automatic logic [pCount_width-1:0] load_for(input state_e s);
    case (s)
      NS_GRN, EW_GRN: load_for = LD_GRN;
      NS_YEL, EW_YEL: load_for = LD_YEL;
      default:        load_for = '0;
    endcase
  endfunction

  // light_tick is not gated by the counter enable, so pause must mask it here
  assign adv = light_tick & run;

  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    case (state_q)
      NS_GRN:  if (adv) state_d = NS_YEL;
      NS_YEL:  if (adv) state_d = night_mode ? FLASH : EW_GRN;
      EW_GRN:  if (adv) state_d = EW_YEL;
      EW_YEL:  if (adv) state_d = night_mode ? FLASH : NS_GRN;
      FLASH:   if (adv) state_d = night_mode ? FLASH : NS_GRN;
      default: state_d = NS_GRN;
    endcase
    if (state_d != FLASH) blink_d = 1'b0;
    else if (adv)         blink_d = (state_q == FLASH) ? ~blink_q : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= NS_GRN;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    ns_light = 3'b001;
    ew_light = 3'b100;
    case (state_q)
      NS_YEL: begin ns_light = 3'b010; ew_light = 3'b100; end
      EW_GRN: begin ns_light = 3'b100; ew_light = 3'b001; end
      EW_YEL: begin ns_light = 3'b100; ew_light = 3'b010; end
      FLASH:  begin ns_light = {1'b0, blink_q, 1'b0}; ew_light = {1'b0, blink_q, 1'b0}; end
      default: ;
    endcase
  end

  // Reload value tracks the state being entered so the counter and phase switch on one edge
  always_comb begin
    if (!rstb)    load_count = LD_GRN;
    else if (adv) load_count = load_for(state_d);
    else          load_count = load_for(state_q);
  end

  assign ctr_load = adv & rstb;
  assign cnt_en   = run;
  assign phase    = state_q;

  a_red_is_green_plus_yellow: assert property (@(posedge clk)
    pRed_Count_Sec == pGreen_Count_Sec + pYellow_Count_Sec);

endmodule
